// File: rtl/async_cpu_pkg.sv
// Shared types for the asynchronous-CPU writeback path: register data/address
// types, the writeback handshake state and the buffered result entry.
package async_cpu_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int ADDR_WIDTH_DEF = 4;

  typedef logic [DATA_WIDTH_DEF-1:0] data_t;
  typedef logic [ADDR_WIDTH_DEF-1:0] addr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic  we;
    addr_t addr;
    data_t data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous result FIFO for the writeback stage; exposes per-slot valid bits
// and the raw slot contents so the top can compare against fetch addresses.
module wb_fifo
  import async_cpu_pkg::*;
#(
  parameter type entry_t = wb_entry_t,
  parameter int  Depth   = 4,
  localparam int PtrW    = $clog2(Depth),
  localparam int CntW    = PtrW + 1,
  localparam int EntryW  = $bits(entry_t)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  entry_t                  push_entry,
  input  logic                    pop,
  output entry_t                  head,
  output logic                    full,
  output logic                    empty,
  output logic [CntW-1:0]         count,
  output logic [Depth-1:0]        entry_vld,
  output logic [Depth*EntryW-1:0] entries_flat
);

  entry_t          mem_q [Depth];
  entry_t          mem_d [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            full_q, full_d;
  logic            do_push, do_pop;
  logic [PtrW-1:0] offs;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    // A push into a full FIFO is fine when the head leaves on the same edge.
    do_push  = push && (!full_q || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    full_d = (count_d == CntW'(Depth));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = (count_q == '0);
  assign count = count_q;

  // Slot i is live when its distance from the read pointer is below the count.
  always_comb begin
    offs         = '0;
    entry_vld    = '0;
    entries_flat = '0;
    for (int i = 0; i < Depth; i++) begin
      offs         = PtrW'(i) - rd_ptr_q;
      entry_vld[i] = CntW'(offs) < count_q;
      entries_flat[i*EntryW +: EntryW] = mem_q[i];
    end
  end

endmodule

// File: rtl/rf_writeback.sv
// Writeback stage: buffers execute results and drains them into the
// asynchronous register file over a 4-phase req/ack handshake.
// Define WB_HAZARD_EN to build the pending-write hazard comparators.
module rf_writeback
  import async_cpu_pkg::*;
#(
  parameter int DataWidth = 16,
  parameter int AddrWidth = 4,
  parameter int Depth     = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_we,
  input  logic [AddrWidth-1:0]   in_addr,
  input  logic [DataWidth-1:0]   in_data,
  output logic                   rf_req,
  input  logic                   rf_ack,
  output logic                   rf_we,
  output logic [AddrWidth-1:0]   rf_addr_w,
  output logic [DataWidth-1:0]   rf_data_in,
  output logic [$clog2(Depth):0] pending_count,
  output logic                   idle,
  input  logic [AddrWidth-1:0]   chk_addr1,
  input  logic [AddrWidth-1:0]   chk_addr2,
  output logic                   hazard1,
  output logic                   hazard2
);

  localparam int CntW   = $clog2(Depth) + 1;
  localparam int EntryW = 1 + AddrWidth + DataWidth;

  typedef struct packed {
    logic                 we;
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] data;
  } entry_t;

  entry_t                  push_entry;
  entry_t                  head;
  logic                    full, empty, push, pop;
  logic [CntW-1:0]         count;
  logic [Depth-1:0]        entry_vld;
  logic [Depth*EntryW-1:0] entries_flat;

  wb_state_e               state_q, state_d;
  logic                    rf_req_q, rf_req_d;
  logic                    rf_we_q, rf_we_d;
  logic [AddrWidth-1:0]    rf_addr_q, rf_addr_d;
  logic [DataWidth-1:0]    rf_data_q, rf_data_d;

  assign push_entry = '{we: in_we, addr: in_addr, data: in_data};
  assign push       = in_valid && !full;

  wb_fifo #(
    .entry_t (entry_t),
    .Depth   (Depth)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push         (push),
    .push_entry   (push_entry),
    .pop          (pop),
    .head         (head),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .entry_vld    (entry_vld),
    .entries_flat (entries_flat)
  );

  // The head stays queued until ack is seen, so queue + in-flight covers
  // every write the register file has not yet committed.
  always_comb begin
    state_d   = state_q;
    rf_req_d  = rf_req_q;
    rf_we_d   = rf_we_q;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && !rf_ack) begin
          rf_req_d  = 1'b1;
          rf_we_d   = head.we;
          rf_addr_d = head.addr;
          rf_data_d = head.data;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (rf_ack) begin
          rf_req_d = 1'b0;
          pop      = 1'b1;
          state_d  = REL;
        end
      end
      REL: begin
        if (!rf_ack) begin
          rf_we_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rf_req_q  <= 1'b0;
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
    end else begin
      state_q   <= state_d;
      rf_req_q  <= rf_req_d;
      rf_we_q   <= rf_we_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
    end
  end

  assign in_ready      = !full;
  assign rf_req        = rf_req_q;
  assign rf_we         = rf_we_q;
  assign rf_addr_w     = rf_addr_q;
  assign rf_data_in    = rf_data_q;
  assign pending_count = count;
  assign idle          = empty && (state_q == IDLE) && !rf_ack;

`ifdef WB_HAZARD_EN
  entry_t slot [Depth];

  always_comb begin
    hazard1 = 1'b0;
    hazard2 = 1'b0;
    for (int i = 0; i < Depth; i++) begin
      slot[i] = entry_t'(entries_flat[i*EntryW +: EntryW]);
      if (entry_vld[i] && slot[i].we && (slot[i].addr == chk_addr1)) hazard1 = 1'b1;
      if (entry_vld[i] && slot[i].we && (slot[i].addr == chk_addr2)) hazard2 = 1'b1;
    end
  end
`else
  logic unused_hazard_inputs;
  assign unused_hazard_inputs = ^{chk_addr1, chk_addr2, entry_vld, entries_flat};
  assign hazard1 = 1'b0;
  assign hazard2 = 1'b0;
`endif

endmodule

// File: tb/tb_rf_writeback.sv
// Bench for rf_writeback: directed scenarios plus random traffic against a
// queue-based model of pending writes and a behavioural register file.
module tb_rf_writeback;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 4;
`ifdef WB_HAZARD_EN
  localparam logic HAZ_ON = 1'b1;
`else
  localparam logic HAZ_ON = 1'b0;
`endif

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  logic                    clk, rst_n;
  logic                    in_valid, in_ready, in_we;
  logic [AW-1:0]           in_addr, chk_addr1, chk_addr2, rf_addr_w;
  logic [DW-1:0]           in_data, rf_data_in;
  logic                    rf_req, rf_ack, rf_we, idle, hazard1, hazard2;
  logic [$clog2(DEPTH):0]  pending_count;

  rf_writeback #(.DataWidth(DW), .AddrWidth(AW), .Depth(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_we         (in_we),
    .in_addr       (in_addr),
    .in_data       (in_data),
    .rf_req        (rf_req),
    .rf_ack        (rf_ack),
    .rf_we         (rf_we),
    .rf_addr_w     (rf_addr_w),
    .rf_data_in    (rf_data_in),
    .pending_count (pending_count),
    .idle          (idle),
    .chk_addr1     (chk_addr1),
    .chk_addr2     (chk_addr2),
    .hazard1       (hazard1),
    .hazard2       (hazard2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int      n_cmp = 0;
  int      n_bad = 0;
  ent_t    pend_q[$];          // results accepted but not yet released by the stage
  ent_t    wr_q[$];            // handshakes the register file still expects, in order
  logic [DW-1:0] rf_mem  [16];
  logic [DW-1:0] ref_mem [16];
  logic    rf_auto, rf_force;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_haz(input logic [AW-1:0] a);
    logic h = 1'b0;
    foreach (pend_q[i]) if (pend_q[i].we && pend_q[i].addr == a) h = 1'b1;
`ifndef WB_HAZARD_EN
    h = 1'b0;
`endif
    return h;
  endfunction

  // Register file: reacts one edge after it sees req change, commits on ack rise.
  initial begin : rf_model
    logic req_s;
    ent_t cur;
    rf_ack = 1'b0;
    cur    = '0;
    forever begin
      @(negedge clk);
      req_s = rf_req;
      @(posedge clk);
      #1;
      if (!rf_auto) begin
        rf_ack = rf_force;
      end else if (req_s && !rf_ack) begin
        if (wr_q.size() == 0) begin
          check_eq("rf_unexpected_req", 32'd1, 32'd0);
        end else begin
          cur = wr_q.pop_front();
          check_eq("rf_we", rf_we, cur.we);
          check_eq("rf_addr", rf_addr_w, cur.addr);
          check_eq("rf_data", rf_data_in, cur.data);
        end
        if (rf_we) rf_mem[rf_addr_w] = rf_data_in;
        rf_ack = 1'b1;
      end else if (!req_s && rf_ack) begin
        check_eq("rf_addr_hold", rf_addr_w, cur.addr);
        check_eq("rf_data_hold", rf_data_in, cur.data);
        rf_ack = 1'b0;
      end
    end
  end

  task automatic check_state();
    check_eq("pending_count", pending_count, pend_q.size());
    check_eq("in_ready", in_ready, pend_q.size() < DEPTH);
    check_eq("hazard1", hazard1, exp_haz(chk_addr1));
    check_eq("hazard2", hazard2, exp_haz(chk_addr2));
  endtask

  // One clock: drive at negedge, advance the model across the edge, check.
  task automatic step(input logic v, input logic we, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, output logic acc);
    logic do_push, do_pop;
    ent_t e;
    in_valid = v; in_we = we; in_addr = a; in_data = d;
    #1;
    do_push = v && in_ready;
    do_pop  = rf_req && rf_ack;
    @(posedge clk);
    if (do_pop && pend_q.size() > 0) begin
      e = pend_q.pop_front();
      if (e.we) ref_mem[e.addr] = e.data;
    end
    if (do_push) begin
      e = '{we: we, addr: a, data: d};
      pend_q.push_back(e);
      wr_q.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
    acc = do_push;
    check_state();
  endtask

  task automatic drain(input string tag);
    int   n = 0;
    logic a;
    while (!(pend_q.size() == 0 && !rf_req && !rf_ack) && n < 300) begin
      step(1'b0, 1'b0, '0, '0, a);
      n++;
    end
    check_eq({tag, "_drain_done"}, n < 300, 1);
    step(1'b0, 1'b0, '0, '0, a);
    check_eq({tag, "_idle"}, idle, 1);
    check_eq({tag, "_wrq_empty"}, wr_q.size(), 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic acc;
    int   pushed, n;
    logic [DW-1:0] old7;
    for (int i = 0; i < 16; i++) begin rf_mem[i] = '0; ref_mem[i] = '0; end
    rst_n = 1'b0; in_valid = 1'b0; in_we = 1'b0; in_addr = '0; in_data = '0;
    chk_addr1 = '0; chk_addr2 = '0; rf_auto = 1'b1; rf_force = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_count", pending_count, 0);
    check_eq("rst_req", rf_req, 0);
    check_eq("rst_we", rf_we, 0);
    check_eq("rst_addr", rf_addr_w, 0);
    check_eq("rst_data", rf_data_in, 0);
    check_eq("rst_idle", idle, 1);
    check_eq("rst_haz", {hazard1, hazard2}, 0);
    rst_n = 1'b1;

    // Single write with request latency
    step(1'b1, 1'b1, 4'd3, 16'hBEEF, acc);
    check_eq("single_req_early", rf_req, 0);
    step(1'b0, 1'b0, '0, '0, acc);
    check_eq("single_req", rf_req, 1);
    check_eq("single_addr", rf_addr_w, 3);
    check_eq("single_data", rf_data_in, 16'hBEEF);
    drain("single");
    check_eq("single_reg3", rf_mem[3], 16'hBEEF);

    // Backpressure: fill with register file stalled, then release
    rf_auto = 1'b0; rf_force = 1'b0; pushed = 0; n = 0;
    while (pushed < 4 && n < 20) begin
      step(1'b1, 1'b1, AW'(pushed), DW'($urandom), acc);
      if (acc) pushed++;
      n++;
    end
    check_eq("full_ready", in_ready, 0);
    check_eq("full_count", pending_count, 4);
    rf_auto = 1'b1;
    while (pushed < 6 && n < 200) begin
      step(1'b1, 1'b1, AW'(pushed), DW'($urandom), acc);
      if (acc) begin
        pushed++;
        if (pushed == 5) check_eq("refill_count", pending_count, 4);
      end
      n++;
    end
    check_eq("burst_pushed", pushed, 6);
    drain("burst");

    // Sequencing token
    old7 = rf_mem[7];
    step(1'b1, 1'b0, 4'd7, 16'h1234, acc);
    step(1'b0, 1'b0, '0, '0, acc);
    check_eq("token_req", rf_req, 1);
    check_eq("token_we", rf_we, 0);
    drain("token");
    check_eq("token_reg7", rf_mem[7], old7);

    // Reset in the middle of a handshake, then a stale ack
    rf_auto = 1'b0; rf_force = 1'b0;
    step(1'b1, 1'b1, 4'd9, 16'hA5A5, acc);
    step(1'b0, 1'b0, '0, '0, acc);
    check_eq("mid_req", rf_req, 1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_req", rf_req, 0);
    check_eq("mid_rst_count", pending_count, 0);
    pend_q.delete();
    wr_q.delete();
    rf_force = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("stale_ack", rf_ack, 1);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 4'd2, 16'h0C0C, acc);
    step(1'b0, 1'b0, '0, '0, acc);
    check_eq("stale_hold1", rf_req, 0);
    step(1'b0, 1'b0, '0, '0, acc);
    check_eq("stale_hold2", rf_req, 0);
    rf_force = 1'b0;
    step(1'b0, 1'b0, '0, '0, acc);
    check_eq("stale_hold3", rf_req, 0);
    step(1'b0, 1'b0, '0, '0, acc);
    check_eq("req_after_stale", rf_req, 1);
    rf_auto = 1'b1;
    drain("rst");

    // Pending-write hazard
    chk_addr1 = 4'd5; chk_addr2 = 4'd6;
    rf_auto = 1'b0; rf_force = 1'b0;
    step(1'b1, 1'b1, 4'd5, DW'($urandom), acc);
    step(1'b0, 1'b0, '0, '0, acc);
    step(1'b0, 1'b0, '0, '0, acc);
    check_eq("haz1_pend", hazard1, HAZ_ON);
    check_eq("haz2_pend", hazard2, 0);
    rf_auto = 1'b1; n = 0;
    while (!rf_ack && n < 20) begin step(1'b0, 1'b0, '0, '0, acc); n++; end
    check_eq("haz_ack_seen", rf_ack, 1);
    check_eq("haz1_at_ack", hazard1, HAZ_ON);
    step(1'b0, 1'b0, '0, '0, acc);
    check_eq("haz1_clear", hazard1, 0);
    drain("haz");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      chk_addr1 = AW'($urandom);
      chk_addr2 = AW'($urandom);
      step($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
           AW'($urandom), DW'($urandom), acc);
    end
    drain("rand");
    for (int i = 0; i < 16; i++) check_eq($sformatf("reg%0d", i), rf_mem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
